// File: rtl/even_seq_pkg.sv
// Shared types and constants for the even-sequence controller.
package even_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned EVEN_STEP = 2;
    // Slice to the datapath width at the point of use to clear bit0.
    localparam logic [31:0] EVEN_MASK = 32'hFFFF_FFFE;

endpackage

// File: rtl/even_value_reg.sv
// Value register for the even sequence: load, step by EVEN_STEP, or hold; flags equality with the limit.
module even_value_reg
    import even_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] value,
    output logic             at_limit
);

    always_ff @(posedge clk) begin
        if (rst)
            value <= '0;
        else if (load)
            value <= load_val;
        else if (inc)
            value <= value + WIDTH'(EVEN_STEP);
    end

    assign at_limit = (value == limit);

endmodule

// File: rtl/even_seq_ctrl.sv
// Handshaked even-value sequencer (one-shot / continuous, start/stop, done and cfg_err pulses).
// Optional beat counter output when EVEN_SEQ_BEAT_COUNT_EN is defined.
module even_seq_ctrl
    import even_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_continuous,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
`ifdef EVEN_SEQ_BEAT_COUNT_EN
    ,
    output logic [WIDTH-1:0] beat_cnt
`endif
);

    localparam logic [WIDTH-1:0] MASK = EVEN_MASK[WIDTH-1:0];

    state_t           state, state_nx;
    logic [WIDTH-1:0] s_q, l_q;
    logic             cont_q;
    logic [WIDTH-1:0] s_in, l_in;
    logic             start_ok, start_rej, hs, at_limit;
    logic             v_load, v_inc;
    logic [WIDTH-1:0] v_load_val;

    assign s_in      = cfg_start & MASK;
    assign l_in      = cfg_limit & MASK;
    assign start_ok  = (state == IDLE) && start && (s_in <= l_in);
    assign start_rej = (state == IDLE) && start && (s_in > l_in);
    assign hs        = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s_q     <= '0;
            l_q     <= '0;
            cont_q  <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nx;
            cfg_err <= start_rej;
            if (start_ok) begin
                s_q    <= s_in;
                l_q    <= l_in;
                cont_q <= cfg_continuous;
            end
        end
    end

    // Stop wins over wrap/DONE; a beat handshaken alongside stop is still
    // considered delivered, but the value is not advanced since the run ends.
    always_comb begin
        state_nx   = state;
        v_load     = 1'b0;
        v_inc      = 1'b0;
        v_load_val = s_q;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nx   = RUN;
                    v_load     = 1'b1;
                    v_load_val = s_in;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nx = IDLE;
                end else if (hs) begin
                    if (!at_limit)
                        v_inc = 1'b1;
                    else if (cont_q)
                        v_load = 1'b1;
                    else
                        state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    even_value_reg #(.WIDTH(WIDTH)) u_val (
        .clk      (clk),
        .rst      (rst),
        .load     (v_load),
        .inc      (v_inc),
        .load_val (v_load_val),
        .limit    (l_q),
        .value    (out_data),
        .at_limit (at_limit)
    );

    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

`ifdef EVEN_SEQ_BEAT_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst || start_ok)
            beat_cnt <= '0;
        else if (hs && (beat_cnt != {WIDTH{1'b1}}))
            beat_cnt <= beat_cnt + 1'b1;
    end
`endif

endmodule

// File: doc/even_seq_ctrl.md
Name: even_seq_ctrl

Overview:
- Sequencing controller for the even-number generator datapath.
- Produces a programmable run of even values, from a start value up to a limit value in steps of 2, on a valid/ready stream.
- Supports one-shot and continuous (wrap-to-start) modes, plus start/stop control and a completion pulse.
- Sits between the host/config side and any consumer of the even sequence; it replaces free-running ripple generation with a handshaked, restartable source.

Parameters:
- WIDTH, 4, width of sequence values; max representable even value is 2^WIDTH-2.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  begin a run; sampled only in IDLE.
- stop  input  1  abort the current run; sampled only in RUN.
- cfg_start  input  WIDTH  first value; bit0 is ignored (forced even).
- cfg_limit  input  WIDTH  last value; bit0 is ignored (forced even).
- cfg_continuous  input  1  1 = wrap to start after limit; 0 = one-shot.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  WIDTH  current even value.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse on natural completion of a one-shot run.
- cfg_err  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - out_valid=0, out_data=0, busy=0, done=0, cfg_err=0.
  - Latched config cleared.
  - Reset has priority over all other inputs in every state, including mid-run and mid-handshake; any pending beat is dropped.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch s = cfg_start with bit0 cleared, l = cfg_limit with bit0 cleared, and cfg_continuous.
  - If s > l: cfg_err=1 for exactly one cycle, remain in IDLE, out_valid stays 0.
  - Otherwise: next cycle state=RUN, out_valid=1, out_data=s, busy=1. Latency from start to first valid beat is 1 cycle.
- RUN, handshake (out_valid & out_ready):
  - If out_data != l: out_data <= out_data + 2.
  - If out_data == l and continuous: out_data <= s (wrap).
  - If out_data == l and one-shot: state <= DONE, out_valid <= 0.
- RUN, no handshake: out_data and out_valid hold stable; no value may change while stalled.
- Sustained throughput: one beat per cycle when out_ready is held high.
- Overflow cannot occur. l <= 2^WIDTH-2 and increments stop at l, so out_data never wraps past 2^WIDTH-1.
- Single-value run (s == l): one beat. One-shot then goes to DONE; continuous re-emits s on every handshake.
- Stop in RUN:
  - Next state is IDLE; out_valid <= 0, busy <= 0, done stays 0.
  - If a handshake occurs in the same cycle, that beat counts as transferred.
  - Stop has priority over the wrap/DONE transition.
- DONE: lasts one cycle with done=1, busy=0, out_valid=0, then IDLE.
  - start is ignored in DONE; it is accepted from the following cycle.
- start is ignored outside IDLE. stop is ignored outside RUN.
- Config inputs are sampled only at accepted start; later changes have no effect on a run in progress.
- out_data retains its last value in IDLE/DONE; consumers must qualify it with out_valid.

Optional Feature:
- Macro: EVEN_SEQ_BEAT_COUNT_EN.
- Defined:
  - Extra output port beat_cnt [WIDTH-1:0], counting accepted handshakes since the last accepted start.
  - Cleared to 0 on rst and on an accepted start.
  - Saturates at 2^WIDTH-1 and holds its value through IDLE/DONE.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package even_seq_pkg:
  - State enum typedef (IDLE, RUN, DONE).
  - Constant EVEN_STEP = 2.
  - Constant EVEN_MASK, used to clear bit0.
- One sub-module, even_value_reg: the WIDTH-bit value register with load/increment-by-2/hold controls and an equal-to-limit compare output.
- FSM, handshake and pulse logic stay in even_seq_ctrl.

Test Plan:
1. WIDTH=4, cfg_start=2, cfg_limit=8, one-shot, out_ready=1 -> beats 2,4,6,8 on 4 consecutive cycles, then done pulse for 1 cycle; busy low afterwards.
2. cfg_start=5, cfg_limit=9 -> bits cleared to 4..8; beats 4,6,8. Then cfg_start=10, cfg_limit=6 -> cfg_err pulses once, no valid beats.
3. Continuous, cfg_start=12, cfg_limit=14, out_ready toggling 1,0,1,1,... -> sequence 12,14,12,14; out_data held stable on every out_ready=0 cycle; done never asserts.
4. Run 0..14 with stop asserted together with a handshake on value 6 -> 6 counted as transferred; out_valid=0 and busy=0 next cycle; no done pulse; a new start 2 cycles later is accepted.
5. rst asserted mid-run while out_valid=1 and out_ready=0 -> next cycle all outputs 0 and state IDLE; start in the same cycle as rst is ignored.
6. With EVEN_SEQ_BEAT_COUNT_EN: cfg_start=14, cfg_limit=14, continuous, 20 handshakes -> beat_cnt saturates at 15; the next accepted start resets it to 0.
